// File: rtl/rd_req_arbiter.sv
// Round-robin read-request arbiter for one base master port: picks an eligible FIFO head,
// pops it, issues the read and holds the port until the response completes.
// Optional response timeout is enabled with `define RD_ARB_TIMEOUT_EN.
//
// Handshake: m_req/m_addr stay asserted/stable until an edge where m_req=1 and m_ack=1;
// the port then waits for m_resp_done (or timeout) before the next arbitration.
module rd_req_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int MASTER_NUM = 2,
    parameter int SLAVE_NUM  = 2,
    parameter int MASTER_IDX = 0,
    parameter int RESP_TMO   = 256
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [SLAVE_NUM-1:0]               req,
    input  logic [SLAVE_NUM*AWIDTH-1:0]        addr,
    input  logic [SLAVE_NUM*MASTER_NUM-1:0]    wren,
    output logic [SLAVE_NUM-1:0]               rd_en,
    output logic                               m_req,
    output logic [AWIDTH-1:0]                  m_addr,
    input  logic                               m_ack,
    input  logic                               m_resp_done,
    output logic [$clog2(SLAVE_NUM)-1:0]       grant_id,
    output logic                               busy,
    output logic                               timeout_err
);

    localparam int IDW = $clog2(SLAVE_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [SLAVE_NUM-1:0] rd_en_q, rd_en_d;
    logic                 m_req_q, m_req_d;
    logic [AWIDTH-1:0]    m_addr_q, m_addr_d;
    logic                 busy_q, busy_d;
    logic                 tmo_q, tmo_d;

    logic [SLAVE_NUM-1:0] elig;
    logic                 found;
    logic [IDW-1:0]       win;
    logic [IDW-1:0]       next_ptr;
    logic                 resp_tmo;
    logic                 wren_unused;

    // Only this port's column of each one-hot wren field matters.
    always_comb begin
        for (int i = 0; i < SLAVE_NUM; i++) begin
            elig[i] = req[i] & wren[i*MASTER_NUM + MASTER_IDX];
        end
    end
    assign wren_unused = ^wren;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < SLAVE_NUM; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= SLAVE_NUM) idx = idx - SLAVE_NUM;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign next_ptr = (grant_id_q == IDW'(SLAVE_NUM - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef RD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(RESP_TMO + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign resp_tmo = (state_q == RESP) && (cnt_q == CW'(RESP_TMO - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == RESP) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign resp_tmo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        rd_en_d    = '0;
        m_req_d    = m_req_q;
        m_addr_d   = m_addr_q;
        tmo_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d   = win;
                    m_addr_d     = addr[int'(win)*AWIDTH +: AWIDTH];
                    rd_en_d[win] = 1'b1;
                    m_req_d      = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                // A done arriving together with the timeout wins; no error is flagged then.
                if (m_resp_done || resp_tmo) begin
                    tmo_d    = !m_resp_done;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: begin
                m_req_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            rd_en_q    <= '0;
            m_req_q    <= 1'b0;
            m_addr_q   <= '0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            rd_en_q    <= rd_en_d;
            m_req_q    <= m_req_d;
            m_addr_q   <= m_addr_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign m_req       = m_req_q;
    assign m_addr      = m_addr_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
`ifdef RD_ARB_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
